// File: rtl/wb_mux_n.sv
// Wishbone 1-to-N address-decoding interconnect with decode-error and watchdog handling.
// One request at a time: decode in IDLE, forward in ACTIVE, single-cycle error in DECERR.
module wb_mux_n #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [ADDR_WIDTH-1:0]              wb_master_adr_i,
    input  logic [DATA_WIDTH-1:0]              wb_master_dat_i,
    output logic [DATA_WIDTH-1:0]              wb_master_dat_o,
    input  logic                               wb_master_we_i,
    input  logic [SELECT_WIDTH-1:0]            wb_master_sel_i,
    input  logic                               wb_master_stb_i,
    input  logic                               wb_master_cyc_i,
    output logic                               wb_master_ack_o,
    output logic                               wb_master_err_o,
    output logic                               wb_master_rty_o,

    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wb_slave_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   wb_slave_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wb_slave_dat_i,
    output logic [NUM_SLAVES-1:0]              wb_slave_we_o,
    output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wb_slave_sel_o,
    output logic [NUM_SLAVES-1:0]              wb_slave_stb_o,
    output logic [NUM_SLAVES-1:0]              wb_slave_cyc_o,
    input  logic [NUM_SLAVES-1:0]              wb_slave_ack_i,
    input  logic [NUM_SLAVES-1:0]              wb_slave_err_i,
    input  logic [NUM_SLAVES-1:0]              wb_slave_rty_i,

    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk,

    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DECERR = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic               req;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic               sl_ack;
    logic               sl_err;
    logic               sl_rty;
    logic [DATA_WIDTH-1:0] sl_dat;
    logic               active;
    logic               expire;
    logic               fwd;
    logic               resp_any;

    assign req = wb_master_cyc_i & wb_master_stb_i;

    // Address decode: lowest matching slave index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (!hit && (((wb_master_adr_i ^ wbs_addr[k*ADDR_WIDTH +: ADDR_WIDTH])
                          & wbs_addr_msk[k*ADDR_WIDTH +: ADDR_WIDTH]) == '0)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // Select the latched slave's response lines; all others are ignored.
    always_comb begin
        sel_oh = '0;
        sl_ack = 1'b0;
        sl_err = 1'b0;
        sl_rty = 1'b0;
        sl_dat = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_oh[k] = 1'b1;
                sl_ack    = wb_slave_ack_i[k];
                sl_err    = wb_slave_err_i[k];
                sl_rty    = wb_slave_rty_i[k];
                sl_dat    = wb_slave_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rst masks every output in the cycle it is asserted, not only after the edge.
    assign active   = (state == ST_ACTIVE) && !rst;
    assign expire   = WDOG_EN && active && wb_master_cyc_i && (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign fwd      = active && req && !expire;

    assign wb_master_ack_o = fwd & sl_ack;
    assign wb_master_rty_o = fwd & sl_rty;
    assign wb_master_err_o = (fwd & sl_err) | expire
                           | ((state == ST_DECERR) && !rst && req);
    assign resp_any        = wb_master_ack_o | wb_master_err_o | wb_master_rty_o;

    assign wb_master_dat_o = active ? sl_dat : '0;
    assign busy_o          = (state != ST_IDLE) && !rst;
    assign timeout_o       = expire;

    // Only the latched slave sees the handshake; the watchdog withdraws stb/cyc on expiry.
    always_comb begin
        wb_slave_stb_o = '0;
        wb_slave_cyc_o = '0;
        wb_slave_we_o  = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (active && sel_oh[k]) begin
                wb_slave_stb_o[k] = wb_master_stb_i & !expire;
                wb_slave_cyc_o[k] = wb_master_cyc_i & !expire;
                wb_slave_we_o[k]  = wb_master_we_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bcast
        assign wb_slave_adr_o[g*ADDR_WIDTH +: ADDR_WIDTH]     = wb_master_adr_i;
        assign wb_slave_dat_o[g*DATA_WIDTH +: DATA_WIDTH]     = wb_master_dat_i;
        assign wb_slave_sel_o[g*SELECT_WIDTH +: SELECT_WIDTH] = wb_master_sel_i;
    end

    // State, latched slave index and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            idx   <= hit_idx;
                            cnt   <= '0;
                            state <= ST_ACTIVE;
                        end else begin
                            state <= ST_DECERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!wb_master_cyc_i || expire || resp_any) begin
                        state <= ST_IDLE;
                    end else if (WDOG_EN) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DECERR: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
